ctrl_unit_pipe: RTL and testbench
=================================

# ctrl_unit_pipe

Registered, parametrised successor to the single-cycle combinational decoder. It decodes the instruction entering EX into registered EX-stage control signals. It also owns three pieces of sequential control: a multi-cycle HI/LO interlock, branch resolution with a one-instruction squash, and multi-channel GPIO enables. It sits between the fetch/ID pipeline register and the EX datapath (ALU, HI/LO, GPIO block).

## Interface
- GPIO_CH, 2: number of GPIO channels, range 1..32; channel index is `instruction[25:21]` (rs field).
- MULT_LAT, 4: cycles a mult/multu occupies HI/LO, range 1..31.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- instr_valid  in  1  `instruction` holds a real instruction this cycle.
- instruction  in  32  instruction presented to decode.
- zero_EX  in  1  ALU zero flag for the instruction currently in EX.
- alu_op  out  4  ALU operation, registered.
- shamt_EX  out  5  shift amount, registered.
- enhilo_EX  out  1  HI/LO write enable, registered.
- regsel_EX  out  2  writeback select: 0 ALU, 1 HI/GPIO, 2 LO; registered.
- regwrite_EX  out  1  register write enable, registered.
- rdrt_EX  out  1  destination select: 1 rt, 0 rd; registered.
- memwrite_EX  out  1  memory write enable, registered.
- alu_src_EX  out  2  ALU B source: 0 reg, 1 sign-extended imm, 2 zero-extended imm; registered.
- gpio_out_en  out  GPIO_CH  one-hot GPIO write enable, registered.
- gpio_in_en  out  GPIO_CH  one-hot GPIO read enable, registered.
- valid_EX  out  1  EX holds a real, non-squashed instruction.
- illegal_EX  out  1  one-cycle pulse: illegal instruction captured.
- pc_src_EX  out  1  branch taken; combinational from EX state and `zero_EX`.
- stall_FETCH  out  1  hold fetch/ID; combinational.

## Operation
**Decode (R-type, opcode 0)**
- add/addu → alu_op 0100.
- sub/subu → alu_op 0101.
- and/or/nor/xor → 0000/0001/0010/0011.
- slt/sltu → 1100/1101.
- sll/srl/sra → 1000/1001/1010, shamt_EX = `instruction[10:6]`.
- mult/multu → 0110/0111, enhilo_EX=1, regwrite_EX=0.
- mfhi → regsel 1; mflo → regsel 2.
- The all-zero word is a NOP: valid_EX=1, every write enable 0.

**GPIO variants (R-type)**
- srl with shamt 0 → gpio_out_en[ch]=1.
- sra with shamt 0 → gpio_in_en[ch]=1, regsel 1.
- ch is `instruction[25:21]`. ch ≥ GPIO_CH is illegal.

**Decode (I-type)**
- All I-types set rdrt_EX=1 and regwrite_EX=1.
- addi/addiu → 0100, alu_src 1.
- andi/ori/xori → 0000/0001/0011, alu_src 2.
- slti → 1100, alu_src 1.
- lui → 1000, shamt 16, alu_src 2, memwrite 0.
- beq (000100)/bne (000101) → 0101, alu_src 0, regwrite 0, rdrt 0; EX marks the branch pending.

**Defaults and illegal**
- Fields not listed for an instruction drive 0; no X is ever driven.
- Unknown opcode/funct, or an illegal GPIO channel, captures a bubble with illegal_EX=1.

**Bubble**
- Every write enable 0, valid_EX=0, alu_op 0, shamt 0.

**State machine (states may overlap)**
- RUN: normal decode.
- HILO_BUSY: hilo_cnt ≠ 0.
- BR_EX: a branch is in EX.

**HI/LO interlock**
- Capturing a mult/multu loads hilo_cnt = MULT_LAT−1.
- hilo_cnt decrements every cycle while ≠ 0.
- hazard = instr_valid & hilo_cnt≠0 & incoming ∈ {mult, multu, mfhi, mflo}.

**Branch**
- pc_src_EX = BR_EX & (beq ? zero_EX : !zero_EX).
- When taken, the instruction presented that cycle is squashed: the next edge captures a bubble.

**Stall**
- stall_FETCH = hazard & !pc_src_EX.
- While stalling, the next edge captures a bubble and upstream holds the instruction.

**Priority**
- rst > squash > stall > decode.
- instr_valid=0 captures a bubble.

## Timing
- Latency: instruction presented in cycle n → EX outputs valid after edge n+1.
- Reset: all registered outputs 0, hilo_cnt 0, BR_EX 0. Consequently pc_src_EX=0 and stall_FETCH=0.
- Reset mid-multiply clears hilo_cnt immediately; no stall follows.
- Pulse widths:
  - enhilo_EX, gpio enables, illegal_EX: exactly one cycle per captured instruction.
  - pc_src_EX: one cycle, during BR_EX.
- mfhi issued k cycles after a mult capture (k ≥ 1):
  - stalls for max(0, MULT_LAT−k) cycles;
  - is then captured.
- MULT_LAT=1 never stalls.
- A taken branch with a hazardous follower: squash only. stall_FETCH=0 and hilo_cnt keeps counting.
- Back-to-back branches: the second branch is squashed if the first is taken.
- hilo_cnt never underflows. Maximum value is MULT_LAT−1.

## Test plan
- Reset release: rst high mid-stream → all outputs 0. Then add (funct 100000) → after one edge alu_op=0100, regwrite_EX=1, valid_EX=1.
- MULT_LAT=4:
  - mult then mfhi immediately → stall_FETCH high for 3 cycles.
  - mfhi captured on the 4th edge with regsel_EX=1.
  - the mult cycle shows enhilo_EX=1 for exactly 1 cycle.
- bne in EX with zero_EX=0 → pc_src_EX=1 and the follower (addi) produces valid_EX=0. With zero_EX=1 → addi executes, alu_src_EX=1.
- GPIO_CH=2:
  - srl rs=1, shamt=0 → gpio_out_en=10.
  - sra rs=0, shamt=0 → gpio_in_en=01, regsel 1.
  - srl rs=3, shamt=0 → illegal_EX=1, no enables.
- lui → shamt_EX=16, alu_src_EX=2, memwrite_EX=0, rdrt_EX=1. ori → alu_src_EX=2.
- rst asserted while hilo_cnt=2, then mflo → no stall; mflo captured next edge with regsel_EX=2.

Source files
------------

// File: rtl/ctrl_unit_pipe_if.sv
// Decode-to-EX control bundle: instruction in from fetch/ID, registered EX controls out.
// The pipeline/bench side drives the master modport; the decoder uses the slave modport.
interface ctrl_unit_pipe_if #(
    parameter int GPIO_CH = 2
);
    logic               instr_valid;
    logic [31:0]        instruction;
    logic               zero_EX;
    logic [3:0]         alu_op;
    logic [4:0]         shamt_EX;
    logic               enhilo_EX;
    logic [1:0]         regsel_EX;
    logic               regwrite_EX;
    logic               rdrt_EX;
    logic               memwrite_EX;
    logic [1:0]         alu_src_EX;
    logic [GPIO_CH-1:0] gpio_out_en;
    logic [GPIO_CH-1:0] gpio_in_en;
    logic               valid_EX;
    logic               illegal_EX;
    logic               pc_src_EX;
    logic               stall_FETCH;

    modport master (
        output instr_valid, instruction, zero_EX,
        input  alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX, memwrite_EX,
               alu_src_EX, gpio_out_en, gpio_in_en, valid_EX, illegal_EX, pc_src_EX, stall_FETCH
    );

    modport slave (
        input  instr_valid, instruction, zero_EX,
        output alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX, memwrite_EX,
               alu_src_EX, gpio_out_en, gpio_in_en, valid_EX, illegal_EX, pc_src_EX, stall_FETCH
    );
endinterface

// File: rtl/ctrl_unit_pipe.sv
// Registered EX-stage decoder with HI/LO interlock, branch squash and GPIO channel enables.
// Latency: one edge from instruction presentation to EX control outputs.
// Backpressure: stall_FETCH holds fetch/ID on HI/LO hazards; a taken branch squashes its follower.
module ctrl_unit_pipe #(
    parameter int GPIO_CH  = 2,
    parameter int MULT_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    ctrl_unit_pipe_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_BEQ  = 6'b000100, OP_BNE  = 6'b000101,
                           OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010,
                           OP_ANDI  = 6'b001100, OP_ORI  = 6'b001101, OP_XORI = 6'b001110,
                           OP_LUI   = 6'b001111;
    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA = 6'b000011,
                           F_MFHI = 6'b010000, F_MFLO = 6'b010010, F_MULT = 6'b011000,
                           F_MULTU = 6'b011001;

    typedef struct packed {
        logic [3:0]         alu_op;
        logic [4:0]         shamt;
        logic               enhilo;
        logic [1:0]         regsel;
        logic               regwrite;
        logic               rdrt;
        logic               memwrite;
        logic [1:0]         alu_src;
        logic [GPIO_CH-1:0] gpio_out_en;
        logic [GPIO_CH-1:0] gpio_in_en;
        logic               valid;
    } ex_ctrl_t;

    logic [5:0]         opcode, funct;
    logic [4:0]         ch, sa;
    logic [GPIO_CH-1:0] ch_oh;
    logic               ch_ok;
    ex_ctrl_t           dec, ex_q;
    logic               dec_ok, dec_mult, dec_branch, dec_beq, hilo_use;
    logic               illegal_q, br_ex, br_beq;
    logic [4:0]         hilo_cnt;
    logic               hazard, capture;

    assign opcode = bus.instruction[31:26];
    assign ch     = bus.instruction[25:21];
    assign sa     = bus.instruction[10:6];
    assign funct  = bus.instruction[5:0];
    assign ch_ok  = 32'(ch) < 32'(GPIO_CH);

    always_comb begin
        ch_oh = '0;
        for (int i = 0; i < GPIO_CH; i++) ch_oh[i] = (ch == 5'(i));
    end

    always_comb begin
        dec        = '0;
        dec_ok     = 1'b1;
        dec_mult   = 1'b0;
        dec_branch = 1'b0;
        dec_beq    = 1'b0;
        dec.valid  = 1'b1;
        if (bus.instruction == 32'd0) begin
            dec.valid = 1'b1;
        end else if (opcode == OP_RTYPE) begin
            dec.regwrite = 1'b1;
            case (funct)
                6'b100000, 6'b100001: dec.alu_op = 4'b0100;
                6'b100010, 6'b100011: dec.alu_op = 4'b0101;
                6'b100100:            dec.alu_op = 4'b0000;
                6'b100101:            dec.alu_op = 4'b0001;
                6'b100111:            dec.alu_op = 4'b0010;
                6'b100110:            dec.alu_op = 4'b0011;
                6'b101010:            dec.alu_op = 4'b1100;
                6'b101011:            dec.alu_op = 4'b1101;
                F_SLL: begin dec.alu_op = 4'b1000; dec.shamt = sa; end
                F_SRL: begin
                    dec.alu_op = 4'b1001;
                    dec.shamt  = sa;
                    if (sa == 5'd0) begin
                        if (ch_ok) dec.gpio_out_en = ch_oh;
                        else       dec_ok = 1'b0;
                    end
                end
                F_SRA: begin
                    dec.alu_op = 4'b1010;
                    dec.shamt  = sa;
                    if (sa == 5'd0) begin
                        if (ch_ok) begin dec.gpio_in_en = ch_oh; dec.regsel = 2'd1; end
                        else       dec_ok = 1'b0;
                    end
                end
                F_MULT, F_MULTU: begin
                    dec.alu_op   = (funct == F_MULT) ? 4'b0110 : 4'b0111;
                    dec.enhilo   = 1'b1;
                    dec.regwrite = 1'b0;
                    dec_mult     = 1'b1;
                end
                F_MFHI: dec.regsel = 2'd1;
                F_MFLO: dec.regsel = 2'd2;
                default: dec_ok = 1'b0;
            endcase
        end else begin
            dec.rdrt     = 1'b1;
            dec.regwrite = 1'b1;
            case (opcode)
                OP_ADDI, OP_ADDIU: begin dec.alu_op = 4'b0100; dec.alu_src = 2'd1; end
                OP_ANDI: begin dec.alu_op = 4'b0000; dec.alu_src = 2'd2; end
                OP_ORI:  begin dec.alu_op = 4'b0001; dec.alu_src = 2'd2; end
                OP_XORI: begin dec.alu_op = 4'b0011; dec.alu_src = 2'd2; end
                OP_SLTI: begin dec.alu_op = 4'b1100; dec.alu_src = 2'd1; end
                OP_LUI:  begin dec.alu_op = 4'b1000; dec.shamt = 5'd16; dec.alu_src = 2'd2; end
                OP_BEQ, OP_BNE: begin
                    dec.alu_op   = 4'b0101;
                    dec.regwrite = 1'b0;
                    dec.rdrt     = 1'b0;
                    dec_branch   = 1'b1;
                    dec_beq      = (opcode == OP_BEQ);
                end
                default: dec_ok = 1'b0;
            endcase
        end
        // Illegal words leave EX as a plain bubble; only illegal_EX marks them.
        if (!dec_ok) begin
            dec        = '0;
            dec_mult   = 1'b0;
            dec_branch = 1'b0;
            dec_beq    = 1'b0;
        end
    end

    assign hilo_use = (opcode == OP_RTYPE) &&
                      (funct == F_MULT || funct == F_MULTU || funct == F_MFHI || funct == F_MFLO);
    assign bus.pc_src_EX   = br_ex & (br_beq ? bus.zero_EX : ~bus.zero_EX);
    assign hazard          = bus.instr_valid & (hilo_cnt != 5'd0) & hilo_use;
    assign bus.stall_FETCH = hazard & ~bus.pc_src_EX;
    assign capture         = bus.instr_valid & ~bus.pc_src_EX & ~hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q      <= '0;
            illegal_q <= 1'b0;
            br_ex     <= 1'b0;
            br_beq    <= 1'b0;
            hilo_cnt  <= 5'd0;
        end else begin
            ex_q      <= capture ? dec : '0;
            illegal_q <= capture & ~dec_ok;
            br_ex     <= capture & dec_branch;
            br_beq    <= dec_beq;
            // The counter keeps running through squashes and stalls alike.
            if (capture && dec_mult)    hilo_cnt <= 5'(MULT_LAT - 1);
            else if (hilo_cnt != 5'd0) hilo_cnt <= hilo_cnt - 5'd1;
        end
    end

    assign bus.alu_op      = ex_q.alu_op;
    assign bus.shamt_EX    = ex_q.shamt;
    assign bus.enhilo_EX   = ex_q.enhilo;
    assign bus.regsel_EX   = ex_q.regsel;
    assign bus.regwrite_EX = ex_q.regwrite;
    assign bus.rdrt_EX     = ex_q.rdrt;
    assign bus.memwrite_EX = ex_q.memwrite;
    assign bus.alu_src_EX  = ex_q.alu_src;
    assign bus.gpio_out_en = ex_q.gpio_out_en;
    assign bus.gpio_in_en  = ex_q.gpio_in_en;
    assign bus.valid_EX    = ex_q.valid;
    assign bus.illegal_EX  = illegal_q;
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Bench for ctrl_unit_pipe: decode vector table, hand-written interlock/branch/reset sequences,
// then random traffic against a table-lookup decode model with a cycle-distance HI/LO model.
module tb_ctrl_unit_pipe;
    localparam int GPIO_CH  = 2;
    localparam int MULT_LAT = 4;

    typedef struct packed {
        logic [3:0]         alu_op;
        logic [4:0]         shamt;
        logic               enhilo;
        logic [1:0]         regsel;
        logic               regwrite;
        logic               rdrt;
        logic               memwrite;
        logic [1:0]         alu_src;
        logic [GPIO_CH-1:0] gout;
        logic [GPIO_CH-1:0] gin;
        logic               valid;
        logic               illegal;
    } exp_t;

    typedef struct packed { exp_t o; logic mult; logic br; logic beq; logic hz; } ref_t;
    typedef struct packed { logic [31:0] instr; exp_t exp; } vec_t;
    typedef struct packed {
        logic r; logic [5:0] code; logic [3:0] alu; logic [1:0] src; logic [1:0] sel;
        logic rw; logic rdrt; logic hilo; logic hu; logic shf; logic br;
    } row_t;

    logic clk, rst;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[$];
    row_t rows[$];

    ctrl_unit_pipe_if #(.GPIO_CH(GPIO_CH)) bus ();
    ctrl_unit_pipe_if #(.GPIO_CH(GPIO_CH)) bus1 ();

    ctrl_unit_pipe #(.GPIO_CH(GPIO_CH), .MULT_LAT(MULT_LAT)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
    ctrl_unit_pipe #(.GPIO_CH(GPIO_CH), .MULT_LAT(1))        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    assign bus1.instr_valid = bus.instr_valid;
    assign bus1.instruction = bus.instruction;
    assign bus1.zero_EX     = bus.zero_EX;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1);
    end

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int sa,
                                          input logic [5:0] fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sa), fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic exp_t E(input logic [3:0] a, input int sh, input logic en, input logic [1:0] sel,
                               input logic rw, input logic rd, input logic [1:0] src,
                               input logic [GPIO_CH-1:0] go, input logic [GPIO_CH-1:0] gi,
                               input logic v, input logic il);
        exp_t e;
        e = '0;
        e.alu_op = a; e.shamt = 5'(sh); e.enhilo = en; e.regsel = sel; e.regwrite = rw;
        e.rdrt = rd; e.alu_src = src; e.gout = go; e.gin = gi; e.valid = v; e.illegal = il;
        return e;
    endfunction

    function automatic exp_t act();
        return {bus.alu_op, bus.shamt_EX, bus.enhilo_EX, bus.regsel_EX, bus.regwrite_EX, bus.rdrt_EX,
                bus.memwrite_EX, bus.alu_src_EX, bus.gpio_out_en, bus.gpio_in_en, bus.valid_EX,
                bus.illegal_EX};
    endfunction

    task automatic add_row(input logic r, input logic [5:0] code, input logic [3:0] alu,
                           input logic [1:0] src, input logic [1:0] sel, input logic rw, input logic rdrt,
                           input logic hilo, input logic hu, input logic shf, input logic br);
        rows.push_back({r, code, alu, src, sel, rw, rdrt, hilo, hu, shf, br});
    endtask

    // Decode reference: look the word up in the instruction table, then apply the GPIO/lui/nop rules.
    function automatic ref_t ref_decode(input logic [31:0] w);
        ref_t r; row_t row; bit hit; bit is_r; logic [5:0] key; int ch; int sa;
        r = '0; row = '0; hit = 0;
        is_r = (w[31:26] == 6'd0);
        key  = is_r ? w[5:0] : w[31:26];
        ch   = int'(w[25:21]);
        sa   = int'(w[10:6]);
        if (w == 32'd0) begin r.o.valid = 1'b1; return r; end
        foreach (rows[i]) if (rows[i].r == is_r && rows[i].code == key) begin hit = 1; row = rows[i]; end
        if (!hit) begin r.o.illegal = 1'b1; return r; end
        if (is_r && sa == 0 && (key == 6'h02 || key == 6'h03) && ch >= GPIO_CH) begin
            r.o.illegal = 1'b1;
            return r;
        end
        r.o.valid    = 1'b1;
        r.o.alu_op   = row.alu;
        r.o.shamt    = row.shf ? 5'(sa) : ((!is_r && key == 6'h0f) ? 5'd16 : 5'd0);
        r.o.enhilo   = row.hilo;
        r.o.regsel   = row.sel;
        r.o.regwrite = row.rw;
        r.o.rdrt     = row.rdrt;
        r.o.alu_src  = row.src;
        if (is_r && sa == 0 && key == 6'h02) for (int i = 0; i < GPIO_CH; i++) r.o.gout[i] = (i == ch);
        if (is_r && sa == 0 && key == 6'h03) begin
            for (int i = 0; i < GPIO_CH; i++) r.o.gin[i] = (i == ch);
            r.o.regsel = 2'd1;
        end
        r.mult = row.hilo;
        r.br   = row.br;
        r.beq  = row.br && key == 6'h04;
        r.hz   = row.hu;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        int   k;
        row_t row;
        k = $urandom_range(0, 29);
        if (k < rows.size()) begin
            row = rows[k];
            if (row.r)
                return r_ins($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                             ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(0, 31), row.code);
            return i_ins(row.code, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535));
        end
        if (k == 26) return 32'd0;
        return $urandom;
    endfunction

    task automatic chk_out(input string nm, input exp_t e);
        exp_t a;
        a = act();
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, a, e);
        end
    endtask

    task automatic chk_bit(input string nm, input logic a, input logic e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %b required %b", nm, a, e);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic z);
        bus.instr_valid = v; bus.instruction = w; bus.zero_EX = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] i_add, i_mult, i_mfhi, i_mflo, i_beq, i_bne, i_addi, w;
        exp_t        x_add, x_mult, x_mfhi, x_mflo, x_addi, bub, ex;
        ref_t        rr;
        int          n, cyc, mult_edge;
        logic        v, z, taken, busy, hazard, hold, br_pend, br_beq;

        i_add  = r_ins(1, 2, 3, 0, 6'h20);
        i_mult = r_ins(1, 2, 0, 0, 6'h18);
        i_mfhi = r_ins(0, 0, 3, 0, 6'h10);
        i_mflo = r_ins(0, 0, 4, 0, 6'h12);
        i_beq  = i_ins(6'h04, 1, 2, 4);
        i_bne  = i_ins(6'h05, 1, 2, 4);
        i_addi = i_ins(6'h08, 1, 2, 5);
        bub    = '0;
        x_add  = E(4'b0100, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        x_mult = E(4'b0110, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        x_mfhi = E(4'b0000, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0);
        x_mflo = E(4'b0000, 0, 0, 2, 1, 0, 0, 0, 0, 1, 0);
        x_addi = E(4'b0100, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0);

        //      r  code   alu      src sel rw rdrt hilo hu shf br
        add_row(1, 6'h20, 4'b0100, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h21, 4'b0100, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h22, 4'b0101, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h23, 4'b0101, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h24, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h25, 4'b0001, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h27, 4'b0010, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h26, 4'b0011, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h2a, 4'b1100, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h2b, 4'b1101, 0, 0, 1, 0, 0, 0, 0, 0);
        add_row(1, 6'h00, 4'b1000, 0, 0, 1, 0, 0, 0, 1, 0);
        add_row(1, 6'h02, 4'b1001, 0, 0, 1, 0, 0, 0, 1, 0);
        add_row(1, 6'h03, 4'b1010, 0, 0, 1, 0, 0, 0, 1, 0);
        add_row(1, 6'h18, 4'b0110, 0, 0, 0, 0, 1, 1, 0, 0);
        add_row(1, 6'h19, 4'b0111, 0, 0, 0, 0, 1, 1, 0, 0);
        add_row(1, 6'h10, 4'b0000, 0, 1, 1, 0, 0, 1, 0, 0);
        add_row(1, 6'h12, 4'b0000, 0, 2, 1, 0, 0, 1, 0, 0);
        add_row(0, 6'h08, 4'b0100, 1, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h09, 4'b0100, 1, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h0c, 4'b0000, 2, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h0d, 4'b0001, 2, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h0e, 4'b0011, 2, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h0a, 4'b1100, 1, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h0f, 4'b1000, 2, 0, 1, 1, 0, 0, 0, 0);
        add_row(0, 6'h04, 4'b0101, 0, 0, 0, 0, 0, 0, 0, 1);
        add_row(0, 6'h05, 4'b0101, 0, 0, 0, 0, 0, 0, 0, 1);

        // Hand-derived decode vectors: {instruction, expected EX controls}.
        vecs.push_back({i_add, x_add});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h21), x_add});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h22), E(4'b0101, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h23), E(4'b0101, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h24), E(4'b0000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h25), E(4'b0001, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h27), E(4'b0010, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h26), E(4'b0011, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h2a), E(4'b1100, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h2b), E(4'b1101, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(0, 2, 3, 5, 6'h00), E(4'b1000, 5, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(0, 2, 3, 3, 6'h02), E(4'b1001, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(0, 2, 3, 7, 6'h03), E(4'b1010, 7, 0, 0, 1, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({i_mult, x_mult});
        vecs.push_back({r_ins(1, 2, 0, 0, 6'h19), E(4'b0111, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({i_mfhi, x_mfhi});
        vecs.push_back({i_mflo, x_mflo});
        vecs.push_back({32'd0, E(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h02), E(4'b1001, 0, 0, 0, 1, 0, 0, 2'b10, 0, 1, 0)});
        vecs.push_back({r_ins(0, 2, 3, 0, 6'h03), E(4'b1010, 0, 0, 1, 1, 0, 0, 0, 2'b01, 1, 0)});
        vecs.push_back({r_ins(3, 2, 3, 0, 6'h02), E(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        vecs.push_back({r_ins(1, 2, 3, 0, 6'h3f), E(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});
        vecs.push_back({i_addi, x_addi});
        vecs.push_back({i_ins(6'h09, 1, 2, 5), x_addi});
        vecs.push_back({i_ins(6'h0c, 1, 2, 5), E(4'b0000, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0)});
        vecs.push_back({i_ins(6'h0d, 1, 2, 5), E(4'b0001, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0)});
        vecs.push_back({i_ins(6'h0e, 1, 2, 5), E(4'b0011, 0, 0, 0, 1, 1, 2, 0, 0, 1, 0)});
        vecs.push_back({i_ins(6'h0a, 1, 2, 5), E(4'b1100, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0)});
        vecs.push_back({i_ins(6'h0f, 0, 2, 16'h1234), E(4'b1000, 16, 0, 0, 1, 1, 2, 0, 0, 1, 0)});
        vecs.push_back({i_beq, E(4'b0101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({i_bne, E(4'b0101, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
        vecs.push_back({i_ins(6'h23, 1, 2, 5), E(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)});

        rst = 1'b1;
        drive(0, 32'd0, 0);
        #10;
        chk_out("reset_out", bub);
        chk_bit("reset_pc_src", bus.pc_src_EX, 1'b0);
        chk_bit("reset_stall", bus.stall_FETCH, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset arriving mid-stream clears outputs without waiting for an edge.
        drive(1, i_mult, 0); tick();
        chk_out("mult_capture", x_mult);
        #2 rst = 1'b1;
        #1;
        chk_out("async_reset_out", bub);
        tick();
        rst = 1'b0;
        drive(1, i_add, 0); tick();
        chk_out("add_after_reset", x_add);

        foreach (vecs[i]) begin
            drive(1, vecs[i].instr, 0); tick();
            chk_out($sformatf("vec%0d_%h", i, vecs[i].instr), vecs[i].exp);
            drive(0, 32'd0, 0); tick();
            chk_out($sformatf("vec%0d_pulse_end", i), bub);
            repeat (3) tick();
        end

        // mult then mfhi straight away: three stall cycles, mfhi lands on the fourth edge.
        drive(1, i_mult, 0); tick();
        chk_out("mult_enhilo", x_mult);
        drive(1, i_mfhi, 0);
        n = 0;
        while (bus.stall_FETCH && n < 10) begin
            chk_bit("lat1_never_stalls", bus1.stall_FETCH, 1'b0);
            tick();
            n++;
            chk_out("stall_bubble", bub);
        end
        chk_bit("mfhi_stall_cycles_eq_3", (n == 3), 1'b1);
        tick();
        chk_out("mfhi_after_stall", x_mfhi);
        drive(0, 32'd0, 0); repeat (4) tick();

        // bne not-equal: follower squashed; bne equal: follower executes.
        drive(1, i_bne, 0); tick();
        drive(1, i_addi, 0);
        chk_bit("bne_taken_pc_src", bus.pc_src_EX, 1'b1);
        chk_bit("bne_taken_stall", bus.stall_FETCH, 1'b0);
        tick();
        chk_out("bne_squash", bub);
        chk_bit("pc_src_one_cycle", bus.pc_src_EX, 1'b0);
        drive(1, i_bne, 0); tick();
        drive(1, i_addi, 1);
        chk_bit("bne_not_taken", bus.pc_src_EX, 1'b0);
        tick();
        chk_out("bne_follower_runs", x_addi);

        // Back-to-back branches: the squashed second branch must not resolve.
        drive(1, i_beq, 0); tick();
        drive(1, i_bne, 1);
        chk_bit("beq_taken", bus.pc_src_EX, 1'b1);
        tick();
        chk_out("second_branch_squashed", bub);
        drive(1, i_addi, 0);
        chk_bit("squashed_branch_no_pc_src", bus.pc_src_EX, 1'b0);
        tick();
        chk_out("after_squashed_branch", x_addi);
        drive(0, 32'd0, 0); repeat (4) tick();

        // Taken branch with a hazardous follower: squash only, counter keeps running.
        drive(1, i_mult, 0); tick();
        drive(1, i_beq, 0); tick();
        drive(1, i_mfhi, 1);
        chk_bit("hz_follower_pc_src", bus.pc_src_EX, 1'b1);
        chk_bit("hz_follower_no_stall", bus.stall_FETCH, 1'b0);
        tick();
        chk_out("hz_follower_squashed", bub);
        drive(1, i_mfhi, 0);
        chk_bit("mfhi_residual_stall", bus.stall_FETCH, 1'b1);
        tick();
        chk_bit("mfhi_stall_done", bus.stall_FETCH, 1'b0);
        tick();
        chk_out("mfhi_after_squash", x_mfhi);
        drive(0, 32'd0, 0); repeat (4) tick();

        // Reset with two HI/LO cycles outstanding: mflo goes straight through.
        drive(1, i_mult, 0); tick();
        drive(0, 32'd0, 0); tick();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        drive(1, i_mflo, 0);
        chk_bit("mflo_no_stall_after_reset", bus.stall_FETCH, 1'b0);
        tick();
        chk_out("mflo_after_reset", x_mflo);
        drive(0, 32'd0, 0); tick();

        // Random traffic against the model; a stalled word is held upstream.
        cyc = 0; mult_edge = -100; br_pend = 0; br_beq = 0; hold = 0;
        v = 0; w = 32'd0;
        for (int t = 0; t < 600; t++) begin
            if (!hold) begin
                v = ($urandom_range(0, 9) != 0);
                w = rand_instr();
            end
            z = 1'($urandom_range(0, 1));
            drive(v, w, z);
            rr     = ref_decode(w);
            taken  = br_pend && (br_beq ? z : !z);
            busy   = (cyc - mult_edge) < (MULT_LAT - 1);
            hazard = v && busy && rr.hz;
            chk_bit($sformatf("rnd%0d_pc_src", t), bus.pc_src_EX, taken);
            chk_bit($sformatf("rnd%0d_stall", t), bus.stall_FETCH, hazard && !taken);
            chk_bit($sformatf("rnd%0d_lat1_stall", t), bus1.stall_FETCH, 1'b0);
            tick();
            cyc++;
            if (v && !taken && !hazard) begin
                ex = rr.o;
                if (rr.mult) mult_edge = cyc;
                br_pend = rr.br;
                br_beq  = rr.beq;
            end else begin
                ex = '0;
                br_pend = 0;
            end
            chk_out($sformatf("rnd%0d_%h", t, w), ex);
            hold = hazard && !taken;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
